// File: rtl/pipelined_barrel_shifter.sv
// Elastic barrel shifter/rotator: one register stage per amount bit, each stage
// conditionally applying a shift of 2^K and tracking the last bit shifted out.

module pbs_stage #(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_vld,
    input  logic             i_shift,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_carry,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);
    localparam int SH = 1 << K;

    logic [WIDTH-1:0] w_data;
    logic             w_carry;
    logic             r_vld;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;

    always_comb begin
        w_data  = i_data;
        w_carry = i_carry;
        if (i_shift) begin
            case (i_op)
                2'b00: begin
                    w_data  = i_data >> SH;
                    w_carry = i_data[SH-1];
                end
                2'b01: begin
                    w_data  = $unsigned($signed(i_data) >>> SH);
                    w_carry = i_data[SH-1];
                end
                2'b10: begin
                    w_data  = i_data << SH;
                    w_carry = i_data[WIDTH-SH];
                end
                default: begin
                    // the bit rotated into the MSB doubles as the carry
                    w_data  = (i_data >> SH) | (i_data << (WIDTH - SH));
                    w_carry = i_data[SH-1];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_data  <= '0;
            r_carry <= 1'b0;
        end else if (i_adv) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data  <= w_data;
                r_carry <= w_carry;
            end
        end
    end

    assign o_vld   = r_vld;
    assign o_data  = r_data;
    assign o_carry = r_carry;
endmodule

module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);
    logic [SW:0]            w_vld;
    logic [SW:0][WIDTH-1:0] w_data;
    logic [SW:0]            w_carry;
    logic [SW-1:0][1:0]     w_op;
    logic [SW-1:0]          w_adv;
    logic                   r_en;

    // in_ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_en <= 1'b0;
        else        r_en <= 1'b1;
    end

    assign w_vld[0]   = in_valid && r_en;
    assign w_data[0]  = in_data;
    assign w_carry[0] = 1'b0;
    assign w_op[0]    = in_op;
    assign in_ready   = r_en && w_adv[0];

    genvar k;
    for (k = 0; k < SW; k++) begin : g_stg
        logic [SW-1:k] w_amt;

        // a stage may load whenever any slot downstream of it is free
        assign w_adv[k] = out_ready || !(&w_vld[SW:k+1]);

        if (k == 0) begin : g_in
            assign w_amt = in_amt;
        end else begin : g_in
            assign w_amt = g_stg[k-1].g_ctl.r_amt;
        end

        // only the amount bits still to be applied travel onward
        if (k < SW-1) begin : g_ctl
            logic [SW-1:k+1] r_amt;
            logic [1:0]      r_op;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_amt <= '0;
                    r_op  <= '0;
                end else if (w_adv[k] && w_vld[k]) begin
                    r_amt <= w_amt[SW-1:k+1];
                    r_op  <= w_op[k];
                end
            end
            assign w_op[k+1] = r_op;
        end

        pbs_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_adv   (w_adv[k]),
            .i_vld   (w_vld[k]),
            .i_shift (w_amt[k]),
            .i_op    (w_op[k]),
            .i_data  (w_data[k]),
            .i_carry (w_carry[k]),
            .o_vld   (w_vld[k+1]),
            .o_data  (w_data[k+1]),
            .o_carry (w_carry[k+1])
        );
    end

    assign out_valid = w_vld[SW];
    assign out_data  = w_data[SW];
    assign out_carry = w_carry[SW];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized checks of the 8-bit pipelined barrel shifter.

module tb_pipelined_barrel_shifter;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int stab_err = 0;
    logic [7:0] rx_d[$];
    logic       rx_c[$];
    int         rx_t[$];
    logic       stall_p = 1'b0;
    logic [7:0] sd;
    logic       sc;

    pipelined_barrel_shifter #(.WIDTH(8), .SW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // output transfers and stall stability, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p && (out_valid !== 1'b1 || out_data !== sd || out_carry !== sc)) stab_err++;
            stall_p = out_valid && !out_ready;
            sd = out_data;
            sc = out_carry;
            if (out_valid && out_ready) begin
                rx_d.push_back(out_data);
                rx_c.push_back(out_carry);
                rx_t.push_back(cyc);
            end
        end
    end

    function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] d, input int amt);
        logic [7:0] r;
        logic       c;
        r = d;
        c = 1'b0;
        if (amt != 0) begin
            case (op)
                2'd0: begin r = d >> amt; c = d[amt-1]; end
                2'd1: begin r = 8'($signed(d) >>> amt); c = d[amt-1]; end
                2'd2: begin r = d << amt; c = d[8-amt]; end
                default: begin r = (d >> amt) | (d << (8 - amt)); c = r[7]; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input logic [7:0] d, input int amt);
        in_valid = 1'b1;
        in_op    = 2'(op);
        in_data  = d;
        in_amt   = 3'(amt);
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_c.delete();
        rx_t.delete();
    endtask

    task automatic wait_rx(input int n);
        for (int w = 0; w < 40 && rx_d.size() < n; w++) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%02h want=00", out_data); end
        n_chk++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL reset_out_carry got=%0b want=0", out_carry); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        rst_n = 1'b1;
        tick();
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_stream();
        int         op [4] = '{0, 1, 2, 3};
        int         am [4] = '{2, 2, 3, 3};
        logic [7:0] ed [4] = '{8'h2D, 8'hED, 8'hA0, 8'h96};
        logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int c0;
        out_ready = 1'b1;
        clear_rx();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drive(op[i], 8'hB4, am[i]);
            n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%0b want=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        wait_rx(4);
        n_chk++; if (rx_d.size() != 4) begin n_fail++; $display("FAIL stream_count got=%0d want=4", rx_d.size()); end
        for (int i = 0; i < 4; i++) begin
            if (rx_d.size() > i) begin
                n_chk++; if (rx_d[i] !== ed[i]) begin n_fail++; $display("FAIL stream_data[%0d] got=%02h want=%02h", i, rx_d[i], ed[i]); end
                n_chk++; if (rx_c[i] !== ec[i]) begin n_fail++; $display("FAIL stream_carry[%0d] got=%0b want=%0b", i, rx_c[i], ec[i]); end
                n_chk++; if (rx_t[i] - c0 != 3 + i) begin n_fail++; $display("FAIL stream_latency[%0d] got=%0d want=%0d", i, rx_t[i] - c0, 3 + i); end
            end
        end
    endtask

    task automatic test_backpressure();
        int         op [4] = '{0, 2, 3, 1};
        logic [7:0] dd [4] = '{8'hF0, 8'h8F, 8'h01, 8'h80};
        int         am [4] = '{4, 1, 1, 1};
        logic [7:0] ed [4] = '{8'h0F, 8'h1E, 8'h80, 8'hC0};
        logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int idx = 0;
        int acc = 0;
        logic took;
        out_ready = 1'b0;
        clear_rx();
        for (int i = 0; i < 6; i++) begin
            drive(op[idx], dd[idx], am[idx]);
            @(negedge clk);
            took = in_ready;
            tick();
            if (took) begin
                acc++;
                if (idx < 3) idx++;
            end
        end
        n_chk++; if (acc != 3) begin n_fail++; $display("FAIL bp_accepts got=%0d want=3", acc); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got=%0b want=1", out_valid); end
        n_chk++; if (out_data !== 8'h0F) begin n_fail++; $display("FAIL bp_frozen_data got=%02h want=0f", out_data); end
        n_chk++; if (out_carry !== 1'b0) begin n_fail++; $display("FAIL bp_frozen_carry got=%0b want=0", out_carry); end
        out_ready = 1'b1;
        #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_full_drain_ready got=%0b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        wait_rx(4);
        n_chk++; if (rx_d.size() != 4) begin n_fail++; $display("FAIL bp_count got=%0d want=4", rx_d.size()); end
        for (int i = 0; i < 4; i++) begin
            if (rx_d.size() > i) begin
                n_chk++; if (rx_d[i] !== ed[i]) begin n_fail++; $display("FAIL bp_data[%0d] got=%02h want=%02h", i, rx_d[i], ed[i]); end
                n_chk++; if (rx_c[i] !== ec[i]) begin n_fail++; $display("FAIL bp_carry[%0d] got=%0b want=%0b", i, rx_c[i], ec[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int         op [6] = '{0, 1, 2, 3, 1, 2};
        int         am [6] = '{0, 0, 0, 0, 7, 1};
        logic [7:0] ed [6] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'hFF, 8'h02};
        logic       ec [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        clear_rx();
        for (int i = 0; i < 6; i++) begin
            drive(op[i], 8'h81, am[i]);
            @(negedge clk);
            n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%0b want=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        wait_rx(6);
        n_chk++; if (rx_d.size() != 6) begin n_fail++; $display("FAIL b2b_count got=%0d want=6", rx_d.size()); end
        for (int i = 0; i < 6; i++) begin
            if (rx_d.size() > i) begin
                n_chk++; if (rx_d[i] !== ed[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got=%02h want=%02h", i, rx_d[i], ed[i]); end
                n_chk++; if (rx_c[i] !== ec[i]) begin n_fail++; $display("FAIL b2b_carry[%0d] got=%0b want=%0b", i, rx_c[i], ec[i]); end
            end
        end
        if (rx_t.size() == 6) begin
            n_chk++; if (rx_t[5] - rx_t[0] != 5) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=5", rx_t[5] - rx_t[0]); end
        end
    endtask

    task automatic test_reset_midflight();
        int c0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2, 8'h11 << i, i + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got=%0b want=0", out_valid); end
        n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_out_data got=%02h want=00", out_data); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready got=%0b want=0", in_ready); end
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_rx();
        repeat (6) tick();
        n_chk++; if (rx_d.size() != 0) begin n_fail++; $display("FAIL mid_rst_stale got=%0d want=0", rx_d.size()); end
        c0 = cyc;
        drive(2, 8'h01, 7);
        tick();
        in_valid = 1'b0;
        wait_rx(1);
        n_chk++; if (rx_d.size() != 1) begin n_fail++; $display("FAIL mid_rst_new_count got=%0d want=1", rx_d.size()); end
        if (rx_d.size() > 0) begin
            n_chk++; if (rx_d[0] !== 8'h80) begin n_fail++; $display("FAIL mid_rst_new_data got=%02h want=80", rx_d[0]); end
            n_chk++; if (rx_c[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_new_carry got=%0b want=0", rx_c[0]); end
            n_chk++; if (rx_t[0] - c0 != 3) begin n_fail++; $display("FAIL mid_rst_new_latency got=%0d want=3", rx_t[0] - c0); end
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [8:0] got;
        int bad = 0;
        clear_rx();
        stab_err = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_op     = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back(model(in_op, in_data, int'(in_amt)));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_rx(exp_q.size());
        n_chk++; if (rx_d.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", rx_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_d.size(); i++) begin
            got = {rx_c[i], rx_d[i]};
            n_chk++;
            if (got !== exp_q[i]) begin
                n_fail++;
                bad++;
                if (bad <= 5) $display("FAIL rand_result[%0d] got=%03h want=%03h", i, got, exp_q[i]);
            end
        end
        n_chk++; if (stab_err != 0) begin n_fail++; $display("FAIL rand_stall_stability got=%0d want=0", stab_err); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_amt = '0;
        in_op = '0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 32: data width; SHALL be a power of two, >= 4.
REQ-002 Parameter SW, default $clog2(WIDTH): shift-amount width and pipeline depth (LAT = SW).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SW  shift/rotate amount, 0..WIDTH-1.
REQ-009 in_op  input  2  00 SRL logical right, 01 SRA arithmetic right, 10 SLL logical left, 11 ROR rotate right.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_data  output  WIDTH  shifted/rotated result.
REQ-013 out_carry  output  1  last bit shifted out (SRL/SRA/SLL); for ROR, equals out_data[WIDTH-1]; 0 when amount = 0.

Function
REQ-014 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-015 Pipeline: SW register stages; stage k applies shift of 2^k when amount bit k = 1, carrying op, remaining amount bits, carry and a valid bit.
REQ-016 Latency: with out_ready held high, a result accepted at edge N SHALL present out_valid = 1 after edge N+SW; throughput one op per cycle.
REQ-017 Elastic flow: stage k SHALL load when stage k is empty or stage k is being emptied into stage k+1 (or output) in the same cycle; no bubble SHALL be retained in front of a stall.
REQ-018 in_ready = !stage0_valid || stage0 advances; in_ready SHALL depend combinationally only on internal valids and out_ready, never on in_valid.
REQ-019 out_valid, out_data, out_carry driven directly from last stage registers; SHALL stay stable while out_valid && !out_ready.
REQ-020 Capacity: SW operations in flight; with out_ready = 0, exactly SW further transfers are accepted, then in_ready = 0.
REQ-021 Simultaneous accept and drain when full: the pipeline SHALL shift by one, keep in_ready = 1, lose no data.
REQ-022 SRA fills vacated MSBs with in_data[WIDTH-1]; SRL/SLL fill with 0; ROR wraps bits LSB to MSB.
REQ-023 Amount 0: out_data = in_data for every op, out_carry = 0.
REQ-024 Carry tracking per stage: carry updated to the bit at position 2^k-1 (right ops) or WIDTH-2^k (SLL) of that stage's input when the stage shifts, else passed through.
REQ-025 Order: results leave in acceptance order; op and amount SHALL never be mixed across in-flight operations.
REQ-026 Bubbles (in_valid = 0) SHALL not produce out_valid pulses.

Reset
REQ-027 While rst_n = 0: all stage valids 0, out_valid = 0, out_data = 0, out_carry = 0, in_ready = 0.
REQ-028 First rising edge after rst_n deasserts: in_ready = 1.
REQ-029 Reset assertion mid-operation SHALL immediately discard all in-flight operations; no result of a pre-reset operation SHALL ever appear.

Verification (WIDTH=8, SW=3)
REQ-030 Stream: ops SRL 0xB4 amt 2, SRA 0xB4 amt 2, SLL 0xB4 amt 3, ROR 0xB4 amt 3 back-to-back, out_ready = 1 -> out_data 0x2D,0xED,0xA0,0x96, out_carry 0,0,1,1, first valid 3 cycles after first accept, consecutive cycles.
REQ-031 Backpressure: out_ready = 0, in_valid = 1 continuously -> exactly 3 accepts then in_ready = 0; out_data frozen; release out_ready -> all results in order, none lost or duplicated.
REQ-032 Full pipeline with out_ready = 1 and in_valid = 1 at same edge -> in_ready stays 1, one in one out per cycle.
REQ-033 Amount 0, all four ops on 0x81 -> out_data 0x81, out_carry 0; SRA 0x81 amt 7 -> 0xFF, out_carry 0.
REQ-034 Reset asserted with 3 ops in flight -> out_valid = 0 immediately; after release no stale result appears; new op SLL 0x01 amt 7 -> 0x80 after 3 cycles.
REQ-035 Random ops/amounts with random in_valid/out_ready against a reference model: all results match, order preserved, out_data stable while stalled.
